// File: rtl/mon_player_pkg.sv
// mon_player_pkg: shared types and constants for the host-bus command player.
`default_nettype none

package mon_player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_DATA = 3'd1,
      ST_SETUP     = 3'd2,
      ST_STROBE    = 3'd3,
      ST_HOLD      = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   localparam int HDR_MARK = 7;
   localparam int HDR_DIR  = 1;
   localparam int HDR_A0   = 0;

   localparam int DEF_BAUD_DIV = 208;
   localparam int DEF_T_SETUP  = 2;
   localparam int DEF_T_PULSE  = 4;
   localparam int DEF_T_HOLD   = 2;

endpackage

`default_nettype wire

// File: rtl/mon_uart_rx.sv
// mon_uart_rx: 8N1 receiver with input synchronizer, mid-bit sampling,
// byte-valid pulse and framing-error pulse.
`default_nettype none

module mon_uart_rx
   import mon_player_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst_x,
   input  logic       sin_i,
   output logic [7:0] data_o,
   output logic       vld_o,
   output logic       ferr_o
);

   localparam int CW   = $clog2(BAUD_DIV);
   localparam int HALF = BAUD_DIV / 2;

   logic            sync1_q, sync2_q;
   rx_state_e       state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            vld_q, ferr_q;

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= sin_i;
         sync2_q <= sync1_q;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               if (!sync2_q) state_q <= RX_START;
            end
            RX_START: begin
               if (cnt_q == CW'(HALF - 1)) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  // A glitch that is high again at mid-start is not a frame.
                  state_q <= sync2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == CW'(BAUD_DIV - 1)) begin
                  cnt_q   <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == CW'(BAUD_DIV - 1)) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     vld_q   <= 1'b1;
                     state_q <= RX_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= RX_WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (sync2_q) state_q <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign data_o = shift_q;
   assign vld_o  = vld_q;
   assign ferr_o = ferr_q;

endmodule

`default_nettype wire

// File: rtl/mon_host_player.sv
// mon_host_player: replays UART command pairs as 8080-style host bus cycles.
// Optional read-data echo on sout when MON_PLAYER_ECHO_EN is defined.
`default_nettype none

module mon_host_player
   import mon_player_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV,
   parameter int T_SETUP  = DEF_T_SETUP,
   parameter int T_PULSE  = DEF_T_PULSE,
   parameter int T_HOLD   = DEF_T_HOLD
) (
   input  logic       clk,
   input  logic       rst_x,
   input  logic       sin,
   output logic       ce_x,
   output logic       a0,
   output logic       wr_x,
   output logic       rd_x,
   output logic [7:0] dat_o,
   output logic       dat_oe,
   input  logic [7:0] dat_i,
   output logic [7:0] rd_data,
   output logic       rd_vld,
   output logic       busy,
   output logic       err,
   output logic       sout
);

   localparam int TMAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                             : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
   localparam int TW   = $clog2(TMAX + 1);

   logic [7:0] rx_byte;
   logic       rx_vld, rx_ferr;

   mon_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk    (clk),
      .rst_x  (rst_x),
      .sin_i  (sin),
      .data_o (rx_byte),
      .vld_o  (rx_vld),
      .ferr_o (rx_ferr)
   );

   logic [7:0]    buf_q;
   logic          buf_full_q;
   state_e        state_q;
   logic [TW-1:0] tmr_q;
   logic          hdr_dir_q, hdr_a0_q;
   logic          ce_q, a0_q, wr_q, rd_q, oe_q;
   logic [7:0]    dat_q, rd_data_q;
   logic          rd_vld_q, err_q;
   logic          w_take, w_ovf, w_resync, w_echo_drop;

   assign w_take   = buf_full_q && (state_q == ST_IDLE || state_q == ST_WAIT_DATA);
   assign w_ovf    = rx_vld && buf_full_q && !w_take;
   assign w_resync = (state_q == ST_IDLE) && buf_full_q && !buf_q[HDR_MARK];

   // A byte landing in the same clock the FSM drains the buffer refills it.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else if (rx_vld && !w_ovf) begin
         buf_q      <= rx_byte;
         buf_full_q <= 1'b1;
      end else if (w_take) begin
         buf_full_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         hdr_dir_q <= 1'b0;
         hdr_a0_q  <= 1'b0;
         ce_q      <= 1'b1;
         a0_q      <= 1'b0;
         wr_q      <= 1'b1;
         rd_q      <= 1'b1;
         oe_q      <= 1'b0;
         dat_q     <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         rd_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (buf_full_q && buf_q[HDR_MARK]) begin
                  hdr_dir_q <= buf_q[HDR_DIR];
                  hdr_a0_q  <= buf_q[HDR_A0];
                  state_q   <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (buf_full_q) begin
                  ce_q    <= 1'b0;
                  a0_q    <= hdr_a0_q;
                  if (!hdr_dir_q) begin
                     oe_q  <= 1'b1;
                     dat_q <= buf_q;
                  end
                  tmr_q   <= TW'(T_SETUP - 1);
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_q == '0) begin
                  if (hdr_dir_q) rd_q <= 1'b0;
                  else           wr_q <= 1'b0;
                  tmr_q   <= TW'(T_PULSE - 1);
                  state_q <= ST_STROBE;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_STROBE: begin
               if (tmr_q == '0) begin
                  wr_q <= 1'b1;
                  rd_q <= 1'b1;
                  if (hdr_dir_q) begin
                     rd_data_q <= dat_i;
                     rd_vld_q  <= 1'b1;
                  end
                  tmr_q   <= TW'(T_HOLD - 1);
                  state_q <= ST_HOLD;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_HOLD: begin
               if (tmr_q == '0) begin
                  ce_q    <= 1'b1;
                  oe_q    <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) err_q <= 1'b0;
      else        err_q <= rx_ferr | w_ovf | w_resync | w_echo_drop;
   end

`ifdef MON_PLAYER_ECHO_EN
   localparam int CW = $clog2(BAUD_DIV);

   logic [9:0]    tx_sh_q;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bits_q;
   logic          tx_busy_q;

   assign w_echo_drop = rd_vld_q && tx_busy_q;

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_bits_q <= '0;
         tx_busy_q <= 1'b0;
      end else if (rd_vld_q && !tx_busy_q) begin
         tx_sh_q   <= {1'b1, rd_data_q, 1'b0};
         tx_cnt_q  <= '0;
         tx_bits_q <= '0;
         tx_busy_q <= 1'b1;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
            tx_cnt_q  <= '0;
            tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
            tx_bits_q <= tx_bits_q + 1'b1;
            if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
         end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end
      end
   end

   assign sout = tx_sh_q[0];
`else
   assign w_echo_drop = 1'b0;
   assign sout        = 1'b1;
`endif

   assign ce_x    = ce_q;
   assign a0      = a0_q;
   assign wr_x    = wr_q;
   assign rd_x    = rd_q;
   assign dat_o   = dat_q;
   assign dat_oe  = oe_q;
   assign rd_data = rd_data_q;
   assign rd_vld  = rd_vld_q;
   assign err     = err_q;
   assign busy    = (state_q != ST_IDLE) || buf_full_q;

endmodule

`default_nettype wire

// File: tb/tb_mon_host_player.sv
// tb_mon_host_player: scoreboard bench; stimulus pushes expected bus cycles,
// a negedge monitor reconstructs each cycle and compares.
`default_nettype none
`timescale 1ns/1ps

module tb_mon_host_player;

   localparam int BD = 8;

   logic       clk = 1'b0;
   logic       rst_x = 1'b0;
   logic       sin = 1'b1;
   logic [7:0] dat_i = 8'h00;
   logic       ce_x, a0, wr_x, rd_x, dat_oe, rd_vld, busy, err, sout;
   logic [7:0] dat_o, rd_data;

   mon_host_player #(.BAUD_DIV(BD), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2)) dut (
      .clk     (clk),
      .rst_x   (rst_x),
      .sin     (sin),
      .ce_x    (ce_x),
      .a0      (a0),
      .wr_x    (wr_x),
      .rd_x    (rd_x),
      .dat_o   (dat_o),
      .dat_oe  (dat_oe),
      .dat_i   (dat_i),
      .rd_data (rd_data),
      .rd_vld  (rd_vld),
      .busy    (busy),
      .err     (err),
      .sout    (sout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       dir;
      logic       a0;
      logic [7:0] data;
   } cyc_t;

   cyc_t       exp_q[$];
   logic [7:0] rd_exp_q[$];
   logic [7:0] echo_q[$];

   int n_vec = 0, n_fail = 0;
   int n_cyc = 0, n_err = 0, n_rdv = 0;
   bit overlap = 0, sout_low = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   // Monitor: rebuilds each ce_x-low window and scores it against exp_q.
   int         ce_len, wr_len, rd_len, st_off, oe_hi;
   logic       cy_a0;
   logic [7:0] cy_wd;
   bit         in_cyc = 0;

   always @(negedge clk) begin
      if (!rst_x) begin
         in_cyc = 0;
      end else begin
         if (err) n_err++;
         if (!wr_x && !rd_x) overlap = 1;
         if (!sout) sout_low = 1;
         if (rd_vld) begin
            n_rdv++;
            if (rd_exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL rd_vld_unexpected: got rd_data 0x%0h, required no pulse", rd_data);
            end else begin
               chk("rd_data", rd_data, rd_exp_q.pop_front());
            end
         end
         if (!ce_x) begin
            if (!in_cyc) begin
               in_cyc = 1; ce_len = 0; wr_len = 0; rd_len = 0;
               st_off = -1; oe_hi = 0; cy_a0 = a0; cy_wd = 8'h00;
            end
            if ((!wr_x || !rd_x) && st_off < 0) st_off = ce_len;
            if (!wr_x) begin wr_len++; cy_wd = dat_o; end
            if (!rd_x) rd_len++;
            if (dat_oe) oe_hi++;
            ce_len++;
         end else if (in_cyc) begin
            cyc_t ex;
            in_cyc = 0;
            n_cyc++;
            if (exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL cycle_unexpected: got a bus cycle with a0=%0d, required none", cy_a0);
            end else begin
               ex = exp_q.pop_front();
               chk("ce_len", ce_len, 8);
               chk("st_off", st_off, 2);
               chk("wr_len", wr_len, ex.dir ? 0 : 4);
               chk("rd_len", rd_len, ex.dir ? 4 : 0);
               chk("oe_len", oe_hi, ex.dir ? 0 : 8);
               chk("a0", cy_a0, ex.a0);
               if (!ex.dir) chk("wr_data", cy_wd, ex.data);
            end
         end
      end
   end

`ifdef MON_PLAYER_ECHO_EN
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge sout);
         repeat (BD / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge clk);
            b[i] = sout;
         end
         repeat (BD) @(negedge clk);
         echo_q.push_back(b);
      end
   end
`endif

   task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
      @(negedge clk);
      sin = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         sin = b[i];
         repeat (BD) @(negedge clk);
      end
      sin = stop_ok;
      repeat (BD) @(negedge clk);
      sin = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pair(input logic [7:0] h, input logic [7:0] d);
      send_byte(h);
      send_byte(d);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      @(negedge clk);
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_busy_timeout"}, (k < 400), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, c0, r0, k;

      repeat (3) @(negedge clk);
      chk("rst_ce_x", ce_x, 1);
      chk("rst_wr_x", wr_x, 1);
      chk("rst_rd_x", rd_x, 1);
      chk("rst_a0", a0, 0);
      chk("rst_dat_o", dat_o, 0);
      chk("rst_dat_oe", dat_oe, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_vld", rd_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_sout", sout, 1);
      rst_x = 1'b1;
      repeat (4) @(negedge clk);

      // Write a0=1, data 0x40
      e0 = n_err;
      exp_q.push_back({1'b0, 1'b1, 8'h40});
      pair(8'h81, 8'h40);
      wait_idle("w40");
      chk("w40_pending", exp_q.size(), 0);
      chk("w40_err", n_err - e0, 0);

      // Read a0=0 returning 0xA5
      e0 = n_err; r0 = n_rdv;
      dat_i = 8'hA5;
      exp_q.push_back({1'b1, 1'b0, 8'h00});
      rd_exp_q.push_back(8'hA5);
      pair(8'h82, 8'h00);
      wait_idle("rA5");
      chk("rA5_pending", exp_q.size(), 0);
      chk("rA5_rdv_cnt", n_rdv - r0, 1);
      chk("rA5_rd_data", rd_data, 8'hA5);
      chk("rA5_err", n_err - e0, 0);

      // Stray data byte, then resync on a proper header
      e0 = n_err; c0 = n_cyc;
      send_byte(8'h33);
      wait_idle("r33");
      chk("r33_err", n_err - e0, 1);
      chk("r33_cycles", n_cyc - c0, 0);
      exp_q.push_back({1'b0, 1'b0, 8'h10});
      pair(8'h80, 8'h10);
      wait_idle("w10");
      chk("w10_pending", exp_q.size(), 0);
      chk("w10_err", n_err - e0, 1);

      // Framing error on a would-be header; next pair reads a0=1
      e0 = n_err; c0 = n_cyc;
      send_byte(8'h81, 1'b0);
      wait_idle("ferr");
      chk("ferr_err", n_err - e0, 1);
      chk("ferr_cycles", n_cyc - c0, 0);
      dat_i = 8'h3C;
      exp_q.push_back({1'b1, 1'b1, 8'h00});
      rd_exp_q.push_back(8'h3C);
      pair(8'h83, 8'h00);
      wait_idle("r3C");
      chk("r3C_pending", exp_q.size(), 0);
      chk("r3C_rd_data", rd_data, 8'h3C);

      // Data byte with bit7 set
      exp_q.push_back({1'b0, 1'b1, 8'hFF});
      pair(8'h81, 8'hFF);
      wait_idle("wFF");
      chk("wFF_pending", exp_q.size(), 0);
      repeat (200) @(negedge clk);

      // Reset asserted during the strobe of a write
      c0 = n_cyc;
      fork
         pair(8'h81, 8'h55);
      join_none
      k = 0;
      while (wr_x && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_wr_seen", (k < 400), 1);
      @(negedge clk);
      #1 rst_x = 1'b0;
      #1;
      chk("rst_mid_ce_x", ce_x, 1);
      chk("rst_mid_wr_x", wr_x, 1);
      chk("rst_mid_dat_oe", dat_oe, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rd_data", rd_data, 0);
      repeat (3) @(negedge clk);
      rst_x = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_mid_no_cycle", n_cyc - c0, 0);
      chk("rst_mid_idle", busy, 0);

      exp_q.push_back({1'b0, 1'b0, 8'h22});
      pair(8'h80, 8'h22);
      wait_idle("w22");
      chk("w22_pending", exp_q.size(), 0);
      repeat (120) @(negedge clk);

      chk("strobe_overlap", overlap, 0);
      chk("rd_pending", rd_exp_q.size(), 0);
`ifdef MON_PLAYER_ECHO_EN
      chk("echo_count", echo_q.size(), 2);
      if (echo_q.size() >= 2) begin
         chk("echo_0", echo_q[0], 8'hA5);
         chk("echo_1", echo_q[1], 8'h3C);
      end
`else
      chk("sout_idle", sout_low, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mon_host_player.md
Name: mon_host_player

Overview:
- Stimulus-side counterpart of the host monitor. It receives a serial command stream on sin (UART 8N1) and replays it as 8080-style host bus cycles (ce_x, a0, wr_x, rd_x, dat) into the S1D13700 under test.
- Lets the bench or a PC drive the LCD controller with recorded or scripted register/VRAM traffic.
- Sits at logic-top level beside the monitor; the monitor can capture the cycles it generates.

Parameters:
- BAUD_DIV, 208: clocks per UART bit (24 MHz / 115200); must be >= 4.
- T_SETUP, 2: clocks from ce_x low, with a0/data valid, to strobe low; >= 1.
- T_PULSE, 4: clocks the wr_x/rd_x strobe is held low; >= 1.
- T_HOLD, 2: clocks after strobe high before ce_x returns high; >= 1.

Ports:
- clk  in  1  clock
- rst_x  in  1  asynchronous active-low reset
- sin  in  1  UART serial command input, idle high
- ce_x  out  1  chip select, active low
- a0  out  1  A0 address (0 = data, 1 = command)
- wr_x  out  1  write strobe, active low
- rd_x  out  1  read strobe, active low
- dat_o  out  8  write data
- dat_oe  out  1  data bus drive enable
- dat_i  in  8  read data from the bus
- rd_data  out  8  last sampled read byte
- rd_vld  out  1  one-clock pulse when rd_data updates
- busy  out  1  high while a command is pending or a bus cycle is active
- err  out  1  one-clock pulse on framing error or overflow
- sout  out  1  echo serial output (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_x.
- Reset values: ce_x=1, wr_x=1, rd_x=1, a0=0, dat_o=0, dat_oe=0, rd_data=0, rd_vld=0, busy=0, err=0, sout=1. The FSM returns to IDLE.
- Reset asserted mid-cycle releases all strobes immediately (asynchronously) and discards any partial byte or command.
- UART RX:
  - sin passes through a 2-flop synchronizer, reset value 1.
  - A falling edge in RX idle starts the bit counter. The start bit is re-checked at BAUD_DIV/2; if high, abort and return to RX idle with no error.
  - Data bits are sampled every BAUD_DIV clocks from that point, LSB first, then the stop bit.
  - Stop bit 0: byte discarded, err pulses, and RX waits for sin high before re-arming.
- Byte buffer: one-deep holding register. A byte completing while the buffer is still full is dropped and err pulses.
- Command format, two bytes per cycle:
  - Header: bit7=1, bit1=dir (0 write, 1 read), bit0=a0; bits6:2 are ignored.
  - Data byte: the value written on a write; ignored on a read, but still required.
- FSM states: IDLE, WAIT_DATA, SETUP, STROBE, HOLD.
  - IDLE: a byte with bit7=1 is latched as the header, then go to WAIT_DATA. A byte with bit7=0 is discarded with an err pulse (resync).
  - WAIT_DATA: any byte is accepted, including bit7=1. Go to SETUP.
  - SETUP: ce_x=0 and a0 driven. On a write, dat_oe=1 and dat_o=data. Lasts T_SETUP clocks.
  - STROBE: wr_x=0 or rd_x=0 for T_PULSE clocks. On a read, dat_i is sampled on the last STROBE clock; rd_data updates and rd_vld pulses on the next clock.
  - HOLD: strobe high, ce_x=0, dat_oe kept for writes, for T_HOLD clocks. Then ce_x=1, dat_oe=0, return to IDLE.
- Timing rules:
  - A total cycle lasts T_SETUP+T_PULSE+T_HOLD clocks with ce_x low.
  - At least 1 clock of ce_x high separates back-to-back cycles.
  - wr_x and rd_x are never low simultaneously.
  - busy = (state != IDLE) or the buffer is full.
- Simultaneous events: a byte arriving while the FSM consumes the buffer in the same clock is accepted; the buffer is cleared before it is refilled.

Optional Feature:
- Macro: MON_PLAYER_ECHO_EN.
- Defined: a UART TX (8N1, BAUD_DIV) transmits rd_data after every rd_vld. A read completing while TX is busy drops the echo and pulses err.
- Undefined: no TX logic is built and sout is tied to 1.

Decomposition:
- Package mon_player_pkg holds:
  - the FSM state enum;
  - header bit positions (HDR_MARK=7, HDR_DIR=1, HDR_A0=0);
  - default timing constants.
- One natural sub-module, mon_uart_rx: synchronizer, bit timing, shift register, byte valid pulse and framing-error pulse. The TX under the macro is small enough to stay inline.

Test Plan (BAUD_DIV=8, T_SETUP=2, T_PULSE=4, T_HOLD=2):
- Send 0x81, 0x40 -> one write cycle with a0=1, dat_o=0x40:
  - ce_x low 8 clocks; wr_x low 4 clocks starting 2 clocks after ce_x falls; rd_x stays 1.
- Send 0x82, 0x00 with dat_i=0xA5 -> read cycle with a0=0, rd_x low 4 clocks, dat_oe=0 throughout:
  - rd_data=0xA5 and a single rd_vld pulse.
  - With the macro defined, sout carries 0xA5 framed 8N1.
- Send 0x33, then 0x80, 0x10 -> err pulses once for 0x33; then a write of 0x10 with a0=0 (resync).
- Send a byte with stop bit 0 -> err pulses, no bus cycle; the next valid pair executes normally.
- Send 0x81, 0xFF -> 0xFF is accepted as data despite bit7=1; a write of 0xFF occurs.
- Assert rst_x during STROBE of a write -> ce_x, wr_x, dat_oe return to their reset values immediately; no further cycle until a new header arrives.
